// File: rtl/pipeline_hazard_ctrl.sv
// Decode hazard/forwarding detection plus PC/flush sequencing for the RAT pipeline.
// Outputs are combinational from inputs and the registered FSM; stalls hold fetch, flushes squash decode.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int NUM_SRC      = 2,
  parameter int TYPE_W       = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_HOLD   = 1,
  parameter bit FWD_EN       = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*REG_W-1:0] src_reg,
  input  logic [NUM_SRC-1:0]       src_read,
  input  logic [REG_W-1:0]         ex_reg,
  input  logic                     ex_wr_en,
  input  logic                     ex_is_load,
  input  logic [REG_W-1:0]         wb_reg,
  input  logic                     wb_wr_en,
  input  logic [TYPE_W-1:0]        instr_type,
  input  logic                     branch_taken,
  input  logic                     interrupt,
  output logic [2*NUM_SRC-1:0]     fwd_sel,
  output logic                     fetch_stall,
  output logic                     imem_addr_mux,
  output logic                     dec_nop,
  output logic                     pc_inc,
  output logic                     pc_load,
  output logic                     pc_reset,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    CHECK = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int HW = (STALL_HOLD > 0) ? $clog2(STALL_HOLD + 1) : 1;
  localparam logic [FW-1:0] F_LOAD = FW'(FLUSH_CYCLES);
  localparam logic [HW-1:0] H_LOAD = HW'(STALL_HOLD);

  state_t              cur, nxt;
  logic [FW-1:0]       fcnt, fcnt_nxt;
  logic [HW-1:0]       hcnt, hcnt_nxt;
  logic [NUM_SRC-1:0]  mex, mwb, haz_src, hard_src;
  logic [2*NUM_SRC-1:0] fwd_raw;
  logic                haz, hard_ex, ret_cls, flush_trig, stall_c;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign mex[g] = src_read[g] && ex_wr_en && (src_reg[g*REG_W +: REG_W] == ex_reg);
    assign mwb[g] = src_read[g] && wb_wr_en && (src_reg[g*REG_W +: REG_W] == wb_reg);
    if (FWD_EN) begin : g_fwd
      // A load in EX has no data yet, so it cannot be bypassed and WB is not a substitute.
      assign fwd_raw[2*g +: 2] = (mex[g] && !ex_is_load) ? 2'b01 :
                                 (!mex[g] && mwb[g])     ? 2'b10 : 2'b00;
      assign haz_src[g]  = mex[g] && ex_is_load;
      assign hard_src[g] = mex[g] && ex_is_load;
    end else begin : g_nofwd
      assign fwd_raw[2*g +: 2] = 2'b00;
      assign haz_src[g]  = mex[g] || mwb[g];
      assign hard_src[g] = mex[g];
    end
  end

  assign haz        = |haz_src;
  assign hard_ex    = |hard_src;
  assign ret_cls    = (32'(instr_type) >= 32'd6) && (32'(instr_type) <= 32'd9);
  assign flush_trig = interrupt || branch_taken || (ret_cls && (cur == CHECK));

  always_comb begin
    nxt      = cur;
    fcnt_nxt = fcnt;
    hcnt_nxt = hcnt;
    unique case (cur)
      CHECK: begin
        if (flush_trig) begin
          nxt      = FLUSH;
          fcnt_nxt = F_LOAD;
        end else if (hard_ex && (STALL_HOLD > 0)) begin
          nxt      = STALL;
          hcnt_nxt = H_LOAD;
        end
      end
      STALL: begin
        if (interrupt || branch_taken) begin
          nxt      = FLUSH;
          fcnt_nxt = F_LOAD;
        end else begin
          hcnt_nxt = hcnt - 1'b1;
          if (hcnt == HW'(1)) nxt = CHECK;
        end
      end
      FLUSH: begin
        // Branches and returns here belong to the squashed path; only an interrupt restarts the count.
        if (interrupt) begin
          fcnt_nxt = F_LOAD;
        end else begin
          fcnt_nxt = fcnt - 1'b1;
          if (fcnt == FW'(1)) nxt = CHECK;
        end
      end
      default: begin
        nxt      = FLUSH;
        fcnt_nxt = F_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur  <= FLUSH;
      fcnt <= F_LOAD;
      hcnt <= '0;
    end else begin
      cur  <= nxt;
      fcnt <= fcnt_nxt;
      hcnt <= hcnt_nxt;
    end
  end

  // A flush overrides any stall: the stalled instruction is on a dead path.
  assign stall_c       = (haz || (cur == STALL)) && !interrupt && !branch_taken;
  assign fetch_stall   = stall_c && !reset;
  assign imem_addr_mux = fetch_stall;
  assign dec_nop       = reset || (cur == FLUSH) || flush_trig || stall_c;
  assign pc_load       = branch_taken && !reset;
  assign pc_inc        = !reset && !pc_load && !fetch_stall;
  assign pc_reset      = reset;
  assign fwd_sel       = reset ? '0 : fwd_raw;
  assign state         = reset ? 2'b10 : cur;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: default config, a no-forwarding config and a 3-source/4-bubble config share one stimulus.
module tb_pipeline_hazard_ctrl;

  logic        clk, reset;
  logic [14:0] src_reg;
  logic [2:0]  src_read;
  logic [4:0]  ex_reg, wb_reg;
  logic        ex_wr_en, ex_is_load, wb_wr_en;
  logic [3:0]  instr_type;
  logic        branch_taken, interrupt;

  logic [3:0] fwd0, fwd1;
  logic [5:0] fwd2;
  logic fs0, im0, dn0, pi0, pl0, pr0;
  logic fs1, im1, dn1, pi1, pl1, pr1;
  logic fs2, im2, dn2, pi2, pl2, pr2;
  logic [1:0] st0, st1, st2;

  int n_vec = 0;
  int n_err = 0;

  pipeline_hazard_ctrl u0 (
    .clk(clk), .reset(reset), .src_reg(src_reg[9:0]), .src_read(src_read[1:0]),
    .ex_reg(ex_reg), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .wb_reg(wb_reg), .wb_wr_en(wb_wr_en), .instr_type(instr_type),
    .branch_taken(branch_taken), .interrupt(interrupt),
    .fwd_sel(fwd0), .fetch_stall(fs0), .imem_addr_mux(im0), .dec_nop(dn0),
    .pc_inc(pi0), .pc_load(pl0), .pc_reset(pr0), .state(st0)
  );

  pipeline_hazard_ctrl #(.FWD_EN(1'b0)) u1 (
    .clk(clk), .reset(reset), .src_reg(src_reg[9:0]), .src_read(src_read[1:0]),
    .ex_reg(ex_reg), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .wb_reg(wb_reg), .wb_wr_en(wb_wr_en), .instr_type(instr_type),
    .branch_taken(branch_taken), .interrupt(interrupt),
    .fwd_sel(fwd1), .fetch_stall(fs1), .imem_addr_mux(im1), .dec_nop(dn1),
    .pc_inc(pi1), .pc_load(pl1), .pc_reset(pr1), .state(st1)
  );

  pipeline_hazard_ctrl #(.NUM_SRC(3), .FLUSH_CYCLES(4)) u2 (
    .clk(clk), .reset(reset), .src_reg(src_reg), .src_read(src_read),
    .ex_reg(ex_reg), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .wb_reg(wb_reg), .wb_wr_en(wb_wr_en), .instr_type(instr_type),
    .branch_taken(branch_taken), .interrupt(interrupt),
    .fwd_sel(fwd2), .fetch_stall(fs2), .imem_addr_mux(im2), .dec_nop(dn2),
    .pc_inc(pi2), .pc_load(pl2), .pc_reset(pr2), .state(st2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    src_reg = '0; src_read = '0; ex_reg = '0; ex_wr_en = 0; ex_is_load = 0;
    wb_reg = '0; wb_wr_en = 0; instr_type = '0; branch_taken = 0; interrupt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clk = 0;
    reset = 1;
    clr();
    // Hazard, branch and interrupt all active under reset: every output must stay gated.
    src_reg[4:0] = 5; src_read = 3'b001; ex_reg = 5; ex_wr_en = 1;
    branch_taken = 1; interrupt = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_dec_nop", 32'(dn0), 1);
      check("rst_pc_reset", 32'(pr0), 1);
      check("rst_state", 32'(st0), 2);
      check("rst_pc_load", 32'(pl0), 0);
      check("rst_pc_inc", 32'(pi0), 0);
      check("rst_fetch_stall", 32'(fs0), 0);
      check("rst_fwd_sel", 32'(fwd0), 0);
    end
    @(posedge clk);
    #1;
    reset = 0;
    clr();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("boot_dec_nop0", 32'(dn0), 32'(i < 2));
      check("boot_state0", 32'(st0), (i < 2) ? 2 : 0);
      check("boot_dec_nop1", 32'(dn1), 32'(i < 2));
      check("boot_dec_nop2", 32'(dn2), 32'(i < 4));
      if (i == 2) check("boot_pc_inc0", 32'(pi0), 1);
      if (i == 2) check("boot_pc_reset0", 32'(pr0), 0);
      tick();
    end

    // EX forward of a non-load
    src_reg[4:0] = 5; src_read = 3'b001; ex_reg = 5; ex_wr_en = 1;
    @(negedge clk);
    check("exfwd_fwd0", 32'(fwd0), 32'h1);
    check("exfwd_stall0", 32'(fs0), 0);
    check("exfwd_nop0", 32'(dn0), 0);
    check("exfwd_inc0", 32'(pi0), 1);
    check("exfwd_fwd1", 32'(fwd1), 0);
    check("exfwd_stall1", 32'(fs1), 1);
    check("exfwd_nop1", 32'(dn1), 1);
    check("exfwd_fwd2", 32'(fwd2), 32'h01);
    tick();
    // Load-use: detect cycle then one STALL hold cycle
    ex_is_load = 1;
    @(negedge clk);
    check("lu_stall0", 32'(fs0), 1);
    check("lu_imem0", 32'(im0), 1);
    check("lu_nop0", 32'(dn0), 1);
    check("lu_inc0", 32'(pi0), 0);
    check("lu_fwd0", 32'(fwd0), 0);
    check("lu_state0", 32'(st0), 0);
    check("lu_stall2", 32'(fs2), 1);
    tick();
    ex_wr_en = 0; ex_is_load = 0; wb_reg = 5; wb_wr_en = 1;
    @(negedge clk);
    check("hold_state0", 32'(st0), 1);
    check("hold_stall0", 32'(fs0), 1);
    check("hold_nop0", 32'(dn0), 1);
    check("hold_fwd0", 32'(fwd0), 32'h2);
    tick();
    @(negedge clk);
    check("wbfwd_stall0", 32'(fs0), 0);
    check("wbfwd_nop0", 32'(dn0), 0);
    check("wbfwd_inc0", 32'(pi0), 1);
    check("wbfwd_fwd0", 32'(fwd0), 32'h2);
    check("wbfwd_stall1", 32'(fs1), 1);
    check("wbfwd_state1", 32'(st1), 0);
    tick();

    // Source 1 matches EX and WB: EX wins
    clr();
    src_reg[9:5] = 3; src_read = 3'b010; ex_reg = 3; ex_wr_en = 1; wb_reg = 3; wb_wr_en = 1;
    @(negedge clk);
    check("prio_fwd0", 32'(fwd0), 32'h4);
    check("prio_stall0", 32'(fs0), 0);
    check("prio_fwd1", 32'(fwd1), 0);
    check("prio_stall1", 32'(fs1), 1);
    check("prio_fwd2", 32'(fwd2), 32'h04);
    tick();
    clr();
    @(negedge clk);
    check("nofwd_hold_state1", 32'(st1), 1);
    check("nofwd_hold_stall1", 32'(fs1), 1);
    check("nofwd_idle_stall0", 32'(fs0), 0);
    tick();

    // Third source hazard on the 3-source instance only
    src_reg[14:10] = 9; src_read = 3'b100; ex_reg = 9; ex_wr_en = 1; ex_is_load = 1;
    @(negedge clk);
    check("src2_stall2", 32'(fs2), 1);
    check("src2_stall0", 32'(fs0), 0);
    tick();
    ex_wr_en = 0; ex_is_load = 0; wb_reg = 9; wb_wr_en = 1;
    @(negedge clk);
    check("src2_state2", 32'(st2), 1);
    check("src2_fwd2", 32'(fwd2), 32'h20);
    check("src2_hold2", 32'(fs2), 1);
    tick();

    // Taken branch flush
    clr();
    branch_taken = 1;
    @(negedge clk);
    check("br_load0", 32'(pl0), 1);
    check("br_inc0", 32'(pi0), 0);
    check("br_nop0", 32'(dn0), 1);
    check("br_state0", 32'(st0), 0);
    tick();
    branch_taken = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("brf_nop0", 32'(dn0), 32'(i < 2));
      check("brf_nop2", 32'(dn2), 32'(i < 4));
      check("brf_state2", 32'(st2), (i < 4) ? 2 : 0);
      tick();
    end

    // Branch with simultaneous load-use hazard: flush wins
    src_reg[4:0] = 7; src_read = 3'b001; ex_reg = 7; ex_wr_en = 1; ex_is_load = 1;
    branch_taken = 1;
    @(negedge clk);
    check("brlu_stall0", 32'(fs0), 0);
    check("brlu_load0", 32'(pl0), 1);
    check("brlu_nop0", 32'(dn0), 1);
    check("brlu_stall1", 32'(fs1), 0);
    tick();
    clr();
    @(negedge clk);
    check("brlu_state0", 32'(st0), 2);
    repeat (4) tick();

    // Return-class boundaries
    instr_type = 5;
    @(negedge clk);
    check("type5_nop0", 32'(dn0), 0);
    tick();
    instr_type = 10;
    @(negedge clk);
    check("type10_nop0", 32'(dn0), 0);
    tick();
    instr_type = 7;
    @(negedge clk);
    check("ret_nop0", 32'(dn0), 1);
    check("ret_state0", 32'(st0), 0);
    tick();
    @(negedge clk);
    check("retf1_nop0", 32'(dn0), 1);
    check("retf1_state0", 32'(st0), 2);
    tick();
    instr_type = 0;
    interrupt = 1;
    @(negedge clk);
    check("retf2_nop0", 32'(dn0), 1);
    tick();
    interrupt = 0;
    @(negedge clk);
    check("irq_r1_state0", 32'(st0), 2);
    check("irq_r1_nop0", 32'(dn0), 1);
    tick();
    @(negedge clk);
    check("irq_r2_state0", 32'(st0), 2);
    check("irq_r2_nop0", 32'(dn0), 1);
    tick();
    @(negedge clk);
    check("irq_done_state0", 32'(st0), 0);
    check("irq_done_nop0", 32'(dn0), 0);
    repeat (3) tick();

    // Interrupt during STALL
    src_reg[4:0] = 4; src_read = 3'b001; ex_reg = 4; ex_wr_en = 1; ex_is_load = 1;
    tick();
    interrupt = 1;
    @(negedge clk);
    check("stirq_state0", 32'(st0), 1);
    check("stirq_stall0", 32'(fs0), 0);
    check("stirq_nop0", 32'(dn0), 1);
    tick();
    clr();
    @(negedge clk);
    check("stirq_flush0", 32'(st0), 2);
    repeat (4) tick();

    // Reset asserted mid-STALL
    src_reg[4:0] = 4; src_read = 3'b001; ex_reg = 4; ex_wr_en = 1; ex_is_load = 1;
    tick();
    @(negedge clk);
    check("prerst_state0", 32'(st0), 1);
    reset = 1;
    clr();
    #1;
    check("midrst_state0", 32'(st0), 2);
    check("midrst_stall0", 32'(fs0), 0);
    check("midrst_nop0", 32'(dn0), 1);
    check("midrst_reset0", 32'(pr0), 1);
    tick();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rerel_state0", 32'(st0), (i < 2) ? 2 : 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard and flush controller for the RAT pipeline: decode-stage register hazard detection, operand forwarding selection, fetch stall, and PC/decode-squash control. It generalises the fixed 2-source, 2-bubble, stall-only controller to N sources, configurable flush depth, optional forwarding with load-use stalls, and a configurable stall hold. It sits between fetch/decode and the PC, EX and WB stage latches.

Parameters:
REG_W, 5, register address width
NUM_SRC, 2, source operands checked per decoded instruction
TYPE_W, 4, instr_type width
FLUSH_CYCLES, 2, bubbles inserted after a flush trigger (>=1)
STALL_HOLD, 1, extra stall cycles after a non-forwardable EX hazard (>=0)
FWD_EN, 1, 1 = forward from EX/WB, 0 = stall on every RAW

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
src_reg  in  NUM_SRC*REG_W  decode source regs, source i at [i*REG_W +: REG_W]
src_read  in  NUM_SRC  source i actually read
ex_reg  in  REG_W  EX destination
ex_wr_en  in  1  EX writes ex_reg
ex_is_load  in  1  EX result not available until WB
wb_reg  in  REG_W  WB destination
wb_wr_en  in  1  WB writes wb_reg
instr_type  in  TYPE_W  decoded class; 6..9 = return/RETI class
branch_taken  in  1  branch resolved taken in EX
interrupt  in  1  interrupt accepted this cycle
fwd_sel  out  2*NUM_SRC  per source: 00 regfile, 01 EX, 10 WB
fetch_stall  out  1  hold fetch latch
imem_addr_mux  out  1  equals fetch_stall
dec_nop  out  1  squash decode output to NOP
pc_inc  out  1  PC increment
pc_load  out  1  PC load branch target
pc_reset  out  1  equals reset (combinational)
state  out  2  00 CHECK, 01 STALL, 10 FLUSH (debug)

Behaviour:
- Per source i: mex = src_read[i] && ex_wr_en && src_reg[i]==ex_reg; mwb is the same against wb_reg/wb_wr_en.
- FWD_EN=1: mex && !ex_is_load -> fwd_sel=01; else mwb -> 10; else 00. EX takes priority over WB. mex && ex_is_load -> hazard.
- FWD_EN=0: fwd_sel always 00; any mex or mwb -> hazard.
- haz = OR over sources. hard_ex = any mex that is not forwardable.
- flush_trig = interrupt || branch_taken || (instr_type in 6..9 && state==CHECK).
- FSM registered; flush counter fcnt is $clog2(FLUSH_CYCLES+1) bits; hold counter hcnt is sized for STALL_HOLD.
- Async reset: state=FLUSH, fcnt=FLUSH_CYCLES, hcnt=0. After reset release, exactly FLUSH_CYCLES NOP cycles follow, then CHECK.
- CHECK:
  - flush_trig -> FLUSH, fcnt=FLUSH_CYCLES.
  - else hard_ex && STALL_HOLD>0 -> STALL, hcnt=STALL_HOLD.
  - else stay.
- STALL: interrupt or branch_taken -> FLUSH (fcnt reload). Else hcnt-- and return to CHECK when hcnt reaches 1.
- FLUSH:
  - interrupt -> fcnt reloads (restart).
  - branch_taken/return ignored (squashed path).
  - fcnt-- and exit to CHECK when fcnt==1.
- stall_c = (haz || state==STALL) && !interrupt && !branch_taken. Flush wins over stall because the stalled instruction is on a dead path.
- fetch_stall = imem_addr_mux = stall_c && !reset.
- dec_nop = reset || state==FLUSH || flush_trig || stall_c.
- pc_load = branch_taken && !reset.
- pc_inc = !reset && !pc_load && !fetch_stall.
- While reset is high: fwd_sel=0, fetch_stall=0, pc_inc=0, pc_load=0, dec_nop=1, pc_reset=1, state=10.
- Reset mid-FLUSH or mid-STALL: immediate return to the reset values above.

Test Plan:
- Reset held 3 cycles, then released -> dec_nop=1 for exactly 2 cycles after release, state 10->00, pc_inc=1 on the 3rd cycle.
- FWD_EN=1: src_reg0=5, src_read=01, ex_reg=5, ex_wr_en=1, ex_is_load=0 -> fwd_sel=01, fetch_stall=0, dec_nop=0. The same with ex_is_load=1 -> fetch_stall=1, dec_nop=1 for 2 cycles (detect + STALL_HOLD=1), pc_inc=0.
- src_reg1=3 matches both ex_reg=3 (non-load) and wb_reg=3 -> fwd_sel[3:2]=01. With FWD_EN=0 -> stall, fwd_sel=0.
- branch_taken=1 in CHECK -> pc_load=1, pc_inc=0, dec_nop=1 that cycle plus 2 FLUSH cycles. branch_taken together with a load-use hazard -> fetch_stall=0, pc_load=1.
- instr_type=7 in CHECK -> 1+2 NOP cycles. interrupt pulse on the 2nd FLUSH cycle -> count restarts: 2 further NOP cycles.
- FLUSH_CYCLES=4, NUM_SRC=3: src_reg2 hazard detected, and branch flush yields 4 trailing NOPs.
